comparator_serial: RTL and testbench
====================================

COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits (>= 2).
REQ-002 The block SHALL have parameter DIGIT, default 4, bits compared per cycle.
REQ-003 WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be >= 1; N = WIDTH/DIGIT is the digit count.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: start  input  1  request to begin a comparison.
REQ-008 Port: signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-009 Port: a, b  input  WIDTH each  operands; sampled with start.
REQ-010 Port: busy  output  1  high while a comparison is in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking valid results.
REQ-012 Port: eq, lt, gt  output  1 each  registered result flags (a==b, a<b, a>b).
REQ-013 Port: cycles  output  clog2(N)+1  number of digits examined for the last result.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE; on acceptance, a, b and signed_mode SHALL be captured into internal registers, the digit index SHALL be set to the MSB digit, and the next state SHALL be RUN.
REQ-016 start SHALL be ignored in RUN, and the captured operands SHALL not change until the next accepted start.
REQ-017 In RUN, one DIGIT-wide slice per cycle SHALL be compared, MSB digit first.
REQ-018 In signed mode, the operand MSBs SHALL be inverted before comparison; no other bit is altered.
REQ-019 If the digits differ, the next state SHALL be DONE, with gt=1 if the captured a digit is larger and lt=1 otherwise; comparison SHALL terminate early.
REQ-020 If the digits are equal and the digit is the LSB digit, the next state SHALL be DONE with eq=1; otherwise the digit index SHALL decrement and the block SHALL stay in RUN.
REQ-021 Latency: for a start sampled at edge T0, done SHALL be high in the cycle after edge T0+k, where k (1..N) is the number of digits examined, and cycles SHALL equal k.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 done SHALL be 1 exactly while in DONE, for a single cycle; DONE SHALL go to IDLE, or to RUN if start is high.
REQ-024 eq, lt, gt and cycles SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-025 After the first completed comparison, exactly one of eq, lt, gt SHALL be 1.
REQ-026 When a new start is accepted, the flags SHALL keep their old values until the new result is written.
REQ-027 For N = 1, the comparison SHALL complete in one RUN cycle with cycles = 1.

Reset
REQ-028 rst_n low SHALL force the state to IDLE immediately, without waiting for a clock edge.
REQ-029 rst_n low SHALL clear busy, done, eq, lt, gt, cycles and the captured operands to 0.
REQ-030 A reset asserted mid-RUN SHALL abandon the comparison, and no done pulse SHALL be produced for it.
REQ-031 The first start after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=16, DIGIT=4)
REQ-032 Unsigned equal: a=0x1234, b=0x1234 -> done 4 cycles after the start edge, eq=1, cycles=4.
REQ-033 MSB differs: unsigned a=0x8000, b=0x7FFF -> gt=1, cycles=1; the same operands with signed_mode=1 -> lt=1, cycles=1.
REQ-034 Late difference: a=0x12F0, b=0x12F1 -> lt=1, cycles=4; a=0x1300, b=0x12FF -> gt=1, cycles=2.
REQ-035 start held high during RUN with new operands -> ignored; the result matches the first operands, busy stays high until DONE.
REQ-036 Back-to-back: start high in the DONE cycle with a=0x0001, b=0x0000 -> RUN directly, gt=1, cycles=4.
REQ-037 rst_n pulsed low during RUN of a 4-digit compare -> outputs are 0 immediately, no done; a following start with a=5, b=9 -> lt=1.

Source files
------------

// File: rtl/comparator_serial.sv
// Serial magnitude comparator: examines one DIGIT-wide slice per cycle, MSB digit first,
// and stops at the first differing digit. Supports unsigned and two's-complement operands.
module comparator_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            signed_mode,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            busy,
  output logic                            done,
  output logic                            eq,
  output logic                            lt,
  output logic                            gt,
  output logic [$clog2(WIDTH/DIGIT):0]    cycles
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             mode_reg, mode_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             eq_reg, eq_next;
  logic             lt_reg, lt_next;
  logic             gt_reg, gt_next;
  logic [CW-1:0]    cycles_reg, cycles_next;

  // Flipping the sign bits maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] a_cmp, b_cmp;
  assign a_cmp = mode_reg ? (a_reg ^ MSB_MASK) : a_reg;
  assign b_cmp = mode_reg ? (b_reg ^ MSB_MASK) : b_reg;

  logic [DIGIT-1:0] a_dig [N];
  logic [DIGIT-1:0] b_dig [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_digit
      assign a_dig[gi] = a_cmp[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_cmp[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] a_sel, b_sel;
  logic [CW-1:0]    k_cur;
  assign a_sel = a_dig[idx_reg];
  assign b_sel = b_dig[idx_reg];
  // Digits examined so far, including the current one.
  assign k_cur = CW'(N) - CW'(idx_reg);

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    mode_next   = mode_reg;
    idx_next    = idx_reg;
    eq_next     = eq_reg;
    lt_next     = lt_reg;
    gt_next     = gt_reg;
    cycles_next = cycles_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          mode_next  = signed_mode;
          idx_next   = IW'(N - 1);
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (a_sel != b_sel) begin
          state_next  = DONE;
          gt_next     = (a_sel > b_sel);
          lt_next     = (a_sel < b_sel);
          eq_next     = 1'b0;
          cycles_next = k_cur;
        end else if (idx_reg == '0) begin
          state_next  = DONE;
          eq_next     = 1'b1;
          lt_next     = 1'b0;
          gt_next     = 1'b0;
          cycles_next = k_cur;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= 1'b0;
      idx_reg    <= '0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
      gt_reg     <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      mode_reg   <= mode_next;
      idx_reg    <= idx_next;
      eq_reg     <= eq_next;
      lt_reg     <= lt_next;
      gt_reg     <= gt_next;
      cycles_reg <= cycles_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign eq     = eq_reg;
  assign lt     = lt_reg;
  assign gt     = gt_reg;
  assign cycles = cycles_reg;

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial (WIDTH=16, DIGIT=4): directed vectors, an arithmetic
// reference model, and a per-cycle compare process for busy/done/flags/cycles.
module tb_comparator_serial;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, eq, lt, gt;
  logic [2:0]  cycles;

  comparator_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   k;
    int   t0;
    int   due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   chk_en = 1'b0;
  logic held_eq = 1'b0, held_lt = 1'b0, held_gt = 1'b0;
  int   held_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: ordering from integer compare, digit count from the highest differing bit.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    exp_t e;
    logic [15:0] d;
    int p;
    d = av ^ bv;
    p = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
    e.eq = (av == bv);
    e.lt = sm ? ($signed(av) < $signed(bv)) : (av < bv);
    e.gt = sm ? ($signed(av) > $signed(bv)) : (av > bv);
    e.k  = (p < 0) ? N : N - (p / DIGIT);
    e.t0 = 0;
    e.due = 0;
    return e;
  endfunction

  // Called at posedge+2; leaves at posedge+2 of the cycle after the start edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    exp_t e;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    e = model(av, bv, sm);
    e.t0 = cyc;
    e.due = cyc + e.k;
    q.push_back(e);
    $display("start a=%h b=%h signed=%0d at cycle %0d: expect eq=%0d lt=%0d gt=%0d cycles=%0d",
             av, bv, sm, cyc, e.eq, e.lt, e.gt, e.k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Directed vectors with hand-computed results; {eq,lt,gt} packed as 3 bits.
  typedef struct {
    logic [15:0] av;
    logic [15:0] bv;
    logic        sm;
    logic [2:0]  flags;
    int          k;
  } vec_t;

  vec_t vecs[8] = '{
    '{16'h1234, 16'h1234, 1'b0, 3'b100, 4},
    '{16'h8000, 16'h7FFF, 1'b0, 3'b001, 1},
    '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1},
    '{16'h12F0, 16'h12F1, 1'b0, 3'b010, 4},
    '{16'h1300, 16'h12FF, 1'b0, 3'b001, 2},
    '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 1},
    '{16'hFFFF, 16'h0001, 1'b0, 3'b001, 1},
    '{16'h00A0, 16'h0050, 1'b0, 3'b001, 3}
  };

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic exp_done, exp_busy;
      exp_done = (q.size() > 0) && (cyc == q[0].due);
      exp_busy = (q.size() > 0) && (cyc >= q[0].t0) && (cyc < q[0].due);
      if (exp_done) begin
        held_eq = q[0].eq; held_lt = q[0].lt; held_gt = q[0].gt; held_k = q[0].k;
        void'(q.pop_front());
        $display("result cycle %0d: eq=%0d lt=%0d gt=%0d cycles=%0d", cyc, eq, lt, gt, cycles);
      end
      chk("done", int'(done), int'(exp_done));
      chk("busy", int'(busy), int'(exp_busy));
      chk("flags", int'({eq, lt, gt}), int'({held_eq, held_lt, held_gt}));
      chk("cycles", int'(cycles), held_k);
    end
  end

  initial begin
    exp_t m;
    #12;
    chk("reset_outputs", int'({busy, done, eq, lt, gt, cycles}), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #2;

    // Pin the model against hand-computed results, then run each vector.
    foreach (vecs[i]) begin
      m = model(vecs[i].av, vecs[i].bv, vecs[i].sm);
      chk("model_flags", int'({m.eq, m.lt, m.gt}), int'(vecs[i].flags));
      chk("model_k", m.k, vecs[i].k);
      issue(vecs[i].av, vecs[i].bv, vecs[i].sm);
      wait_idle();
      chk("vec_flags", int'({eq, lt, gt}), int'(vecs[i].flags));
      chk("vec_cycles", int'(cycles), vecs[i].k);
      repeat (2) @(posedge clk);
      #2;
    end

    // start held through RUN with different operands must be ignored.
    issue(16'h1234, 16'h1234, 1'b0);
    start = 1'b1; a = 16'h0000; b = 16'hFFFF;
    repeat (2) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    wait_idle();
    chk("held_start_eq", int'({eq, lt, gt}), 4);

    // Back-to-back: new start during the DONE cycle.
    @(posedge clk); #2;
    issue(16'h1234, 16'h1235, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0 && cyc != q[0].due; i++) begin
      @(posedge clk); #2;
    end
    chk("b2b_in_done", int'(done), 1);
    issue(16'h0001, 16'h0000, 1'b0);
    wait_idle();
    chk("b2b_gt", int'({eq, lt, gt}), 1);
    chk("b2b_cycles", int'(cycles), 4);

    // Reset mid-RUN: outputs clear immediately and the comparison is abandoned.
    @(posedge clk); #2;
    issue(16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({busy, done, eq, lt, gt, cycles}), 0);
    q.delete();
    held_eq = 1'b0; held_lt = 1'b0; held_gt = 1'b0; held_k = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
    end
    issue(16'h0005, 16'h0009, 1'b0);
    wait_idle();
    chk("post_reset_lt", int'({eq, lt, gt}), 2);
    chk("post_reset_cycles", int'(cycles), 4);
    repeat (3) @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
